// File: rtl/piso_shift_reg_pkg.sv
// piso_shift_reg_pkg -- shared definitions for the parallel-in/serial-out
// shift register.
//   state_t : FSM state encoding (IDLE=1'b0, SHIFT=1'b1). This is the only
//             place the encoding is defined; the RTL and the bench both import it.
package piso_shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that must hold every value from 0 to max_val inclusive.
  function automatic int count_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg_if.sv
// piso_shift_reg_if -- parallel-load / serial-out bus.
//   din      : parallel word (master -> slave)
//   load     : load request (master -> slave)
//   shift_en : shift strobe (master -> slave)
//   sout     : serial output bit (slave -> master)
//   q_par    : current register contents (slave -> master)
//   busy     : high while a word is being shifted (slave -> master)
//   done     : one-cycle pulse after the last bit (slave -> master)
//
// Handshake: a word is accepted on a rising edge where load=1 and busy=0.
// While busy=1, load is ignored. Each rising edge with shift_en=1 and busy=1
// consumes the bit on sout. shift_en has no effect while busy=0.
interface piso_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             shift_en;
  logic             sout;
  logic [WIDTH-1:0] q_par;
  logic             busy;
  logic             done;

  modport master (
    output din, load, shift_en,
    input  sout, q_par, busy, done
  );

  modport slave (
    input  din, load, shift_en,
    output sout, q_par, busy, done
  );
endinterface

// File: rtl/piso_shift_reg_dff.sv
// dff -- D flip-flop with an asynchronous active-high reset.
//   clk : clock (rising edge)
//   rst : asynchronous reset, forces q=0
//   d   : data input
//   q   : registered output
//   qb  : complement of q
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/piso_shift_reg.sv
// piso_shift_reg -- parallel-in / serial-out shift register with a two-state
// IDLE/SHIFT controller.
//   clk     : clock, all state changes on the rising edge
//   rst     : asynchronous active-high reset
//   bus     : piso_shift_reg_if slave (din, load, shift_en, sout, q_par,
//             busy, done)
//   state_o : current FSM state, for observation
// Parameters:
//   WIDTH     : parallel word width, 1..32
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic      clk,
  input  logic      rst,
  piso_shift_reg_if.slave bus,
  output state_t    state_o
);

  localparam int CW = count_width(WIDTH);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_qb;
  logic [WIDTH-1:0] reg_d;

  logic             load_acc;
  logic             shift_acc;
  logic             last_shift;
  logic             out_bit;

  assign load_acc   = (state_q == IDLE)  && bus.load;
  assign shift_acc  = (state_q == SHIFT) && bus.shift_en;
  assign last_shift = shift_acc && (cnt_q == CW'(1));

  // Register next value: capture on an accepted load, move one position
  // toward the output end (zero-filling) on an accepted shift, else hold.
  always_comb begin
    reg_d = reg_q;
    if (load_acc) begin
      reg_d = bus.din;
    end else if (shift_acc) begin
      if (MSB_FIRST != 0) begin
        reg_d = reg_q << 1;
      end else begin
        reg_d = reg_q >> 1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff u_bit (
      .clk (clk),
      .rst (rst),
      .d   (reg_d[i]),
      .q   (reg_q[i]),
      .qb  (reg_qb[i])
    );
  end

  // Controller: state, bit counter and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            state_q <= SHIFT;
            cnt_q   <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            // Guard keeps the counter from wrapping below zero.
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
            if (last_shift) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_bit   = (MSB_FIRST != 0) ? reg_q[WIDTH-1] : reg_q[0];
  assign bus.sout  = (state_q == SHIFT) && out_bit;
  // Parallel view taken from the complementary flop outputs.
  assign bus.q_par = ~reg_qb;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg -- directed bench for piso_shift_reg. Three instances:
// WIDTH=8 MSB first, WIDTH=8 LSB first, WIDTH=1.
module tb_piso_shift_reg;
  import piso_shift_reg_pkg::*;

  logic   clk;
  logic   rst;
  state_t st_m;
  state_t st_l;
  state_t st_1;

  int total = 0;
  int bad   = 0;

  piso_shift_reg_if #(.WIDTH(8)) if_m ();
  piso_shift_reg_if #(.WIDTH(8)) if_l ();
  piso_shift_reg_if #(.WIDTH(1)) if_1 ();

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1)) u_m (
    .clk(clk), .rst(rst), .bus(if_m), .state_o(st_m)
  );
  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(0)) u_l (
    .clk(clk), .rst(rst), .bus(if_l), .state_o(st_l)
  );
  piso_shift_reg #(.WIDTH(1), .MSB_FIRST(1)) u_1 (
    .clk(clk), .rst(rst), .bus(if_1), .state_o(st_1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] held;
    int         dn;

    rst = 1'b1;
    if_m.din = '0; if_m.load = 1'b0; if_m.shift_en = 1'b0;
    if_l.din = '0; if_l.load = 1'b0; if_l.shift_en = 1'b0;
    if_1.din = '0; if_1.load = 1'b0; if_1.shift_en = 1'b0;

    // Reset state, before any clock edge
    #2;
    chk("rst_sout_m",  if_m.sout,  0);
    chk("rst_busy_m",  if_m.busy,  0);
    chk("rst_done_m",  if_m.done,  0);
    chk("rst_qpar_m",  if_m.q_par, 0);
    chk("rst_state_m", st_m,       IDLE);
    chk("rst_qpar_l",  if_l.q_par, 0);
    chk("rst_busy_1",  if_1.busy,  0);
    #1 rst = 1'b0;
    step();

    // A5 through both 8-bit instances
    w = 8'hA5;
    if_m.din = w; if_m.load = 1'b1;
    if_l.din = w; if_l.load = 1'b1;
    step();
    if_m.load = 1'b0; if_l.load = 1'b0;
    chk("a5_busy_m",  if_m.busy, 1);
    chk("a5_state_m", st_m,      SHIFT);
    if_m.shift_en = 1'b1; if_l.shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_sout_m[%0d]", i), if_m.sout, w[7-i]);
      chk($sformatf("a5_sout_l[%0d]", i), if_l.sout, w[i]);
      chk($sformatf("a5_done_m[%0d]", i), if_m.done, 0);
      if (i == 3) chk("a5_qpar_l_3", if_l.q_par, 8'h14);
      step();
    end
    chk("a5_done_m",   if_m.done, 1);
    chk("a5_busy_m_e", if_m.busy, 0);
    chk("a5_sout_m_e", if_m.sout, 0);
    chk("a5_done_l",   if_l.done, 1);
    step();
    chk("a5_done_m_1c", if_m.done, 0);
    chk("idle_shift_busy_m", if_m.busy, 0);
    if_m.shift_en = 1'b0; if_l.shift_en = 1'b0;

    // FF with shift_en toggling 1,0,1,0...
    if_m.din = 8'hFF; if_m.load = 1'b1;
    step();
    if_m.load = 1'b0;
    dn = 0;
    for (int k = 1; k <= 16; k++) begin
      if_m.shift_en = (k % 2 == 1);
      held = if_m.q_par;
      step();
      if (if_m.done) dn++;
      if (k == 1)  chk("ff_qpar_1", if_m.q_par, 8'hFE);
      if (k % 2 == 0) chk($sformatf("ff_hold[%0d]", k), if_m.q_par, held);
      if (k == 14) chk("ff_busy_14", if_m.busy, 1);
      if (k == 15) begin
        chk("ff_done_15", if_m.done, 1);
        chk("ff_busy_15", if_m.busy, 0);
      end
    end
    chk("ff_done_count", dn, 1);
    if_m.shift_en = 1'b0;

    // load ignored during SHIFT and on the final shift edge
    if_m.din = 8'hF0; if_m.load = 1'b1;
    step();
    if_m.load = 1'b0; if_m.shift_en = 1'b1;
    step(); step();
    if_m.din = 8'h3C; if_m.load = 1'b1;
    step();
    if_m.load = 1'b0;
    chk("ld_mid_qpar", if_m.q_par, 8'h80);
    chk("ld_mid_busy", if_m.busy,  1);
    step(); step(); step(); step();
    if_m.load = 1'b1;
    step();
    chk("ld_last_done", if_m.done,  1);
    chk("ld_last_busy", if_m.busy,  0);
    chk("ld_last_qpar", if_m.q_par, 8'h00);
    step();
    if_m.load = 1'b0;
    chk("ld_idle_qpar", if_m.q_par, 8'h3C);
    chk("ld_idle_busy", if_m.busy,  1);
    chk("ld_idle_done", if_m.done,  0);
    chk("ld_idle_sout", if_m.sout,  0);
    for (int i = 0; i < 8; i++) step();
    chk("ld_3c_done", if_m.done, 1);
    if_m.shift_en = 1'b0;
    step();

    // Asynchronous reset after 4 shifts
    if_m.din = 8'hC3; if_m.load = 1'b1;
    step();
    if_m.load = 1'b0; if_m.shift_en = 1'b1;
    step(); step(); step(); step();
    chk("ar_pre_qpar", if_m.q_par, 8'h30);
    #2 rst = 1'b1;
    #1;
    chk("ar_sout",  if_m.sout,  0);
    chk("ar_busy",  if_m.busy,  0);
    chk("ar_done",  if_m.done,  0);
    chk("ar_qpar",  if_m.q_par, 0);
    chk("ar_state", st_m,       IDLE);
    #1 rst = 1'b0;
    step();
    chk("ar_no_done", if_m.done, 0);
    chk("ar_idle",    if_m.busy, 0);
    if_m.shift_en = 1'b0;
    w = 8'h81;
    if_m.din = w; if_m.load = 1'b1;
    step();
    if_m.load = 1'b0; if_m.shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ar81_sout[%0d]", i), if_m.sout, w[7-i]);
      step();
    end
    chk("ar81_done", if_m.done, 1);
    chk("ar81_busy", if_m.busy, 0);
    if_m.shift_en = 1'b0;

    // WIDTH=1
    if_1.din = 1'b1; if_1.load = 1'b1;
    step();
    if_1.load = 1'b0;
    chk("w1_busy", if_1.busy, 1);
    chk("w1_sout", if_1.sout, 1);
    if_1.shift_en = 1'b1;
    step();
    chk("w1_done",   if_1.done, 1);
    chk("w1_sout_e", if_1.sout, 0);
    chk("w1_busy_e", if_1.busy, 0);
    step();
    chk("w1_done_1c", if_1.done, 0);
    chk("w1_idle",    if_1.busy, 0);
    if_1.shift_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_shift_reg.md
PISO_SHIFT_REG -- requirements
Module: piso_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width in bits (legal range 1..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the shift order: 1 shifts the MSB out first, 0 shifts the LSB out first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 din  input  WIDTH  SHALL be the parallel word, sampled only when a load is accepted.
REQ-006 load  input  1  SHALL be the load request, honoured only in IDLE.
REQ-007 shift_en  input  1  SHALL be the shift strobe: one bit advances per rising edge while asserted in SHIFT.
REQ-008 sout  output  1  SHALL be the current outgoing serial bit.
REQ-009 q_par  output  WIDTH  SHALL be the current shift-register contents.
REQ-010 busy  output  1  SHALL be high while in SHIFT.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking completion of a word.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 In IDLE with load=1, the next rising edge SHALL capture din into the register, set the bit counter to WIDTH and enter SHIFT.
REQ-014 In SHIFT with shift_en=1, each rising edge SHALL shift the register by one position toward the output end, zero-fill the vacated bit and decrement the counter.
REQ-015 In SHIFT with shift_en=0, the register, counter and state SHALL hold.
REQ-016 In SHIFT, sout SHALL equal the register bit at the output end (bit WIDTH-1 when MSB_FIRST=1, else bit 0), driven combinationally from the register.
REQ-017 In IDLE, sout SHALL be 0.
REQ-018 The shift edge with counter=1 SHALL return the FSM to IDLE and assert done for exactly the following clock cycle.
REQ-019 load SHALL be ignored while in SHIFT, including on the final shift edge; a load asserted then is accepted in the first IDLE cycle.
REQ-020 shift_en SHALL be ignored in IDLE.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap below 0.
REQ-022 With WIDTH=1, a word SHALL complete after a single shift edge.
REQ-023 Latency: the first bit SHALL be valid on sout in the cycle after the load edge; the last bit SHALL be consumed WIDTH shift edges after the load edge.

Reset
REQ-024 While rst=1, the block SHALL force: state=IDLE, register=0, counter=0, q_par=0, busy=0, done=0 and sout=0, independent of clk.
REQ-025 Reset asserted mid-word SHALL abort the word without producing a done pulse; operation SHALL resume from IDLE on the first rising edge after rst deasserts.

Structure
REQ-026 The state encodings (IDLE=1'b0, SHIFT=1'b1) SHALL be defined once as constants in a shared include file, piso_defs, reused by the bench.
REQ-027 Each register bit SHALL be built from instances of a single sub-module, dff (D flip-flop with q, qb, d, clk and an asynchronous active-high rst); the FSM and counter MAY be behavioural.

Verification
REQ-028 Configuration: WIDTH=8, MSB_FIRST=1. Stimulus: load din=8'hA5, then hold shift_en=1. Required: sout sequence 1,0,1,0,0,1,0,1; done high exactly one cycle after the 8th shift edge; busy then low.
REQ-029 Configuration: MSB_FIRST=0. Stimulus: din=8'hA5. Required: sout sequence 1,0,1,0,0,1,0,1 taken LSB first (bit 0 first); q_par after 3 shifts = 8'h14.
REQ-030 Stimulus: din=8'hFF loaded; shift_en toggled 1,0,1,0... Required: completion takes 16 cycles; q_par holds during shift_en=0 cycles; done pulse occurs once.
REQ-031 Stimulus: load=1 with din=8'h3C during SHIFT, and again on the final shift edge. Required: both ignored; the following IDLE cycle with load=1 captures 8'h3C.
REQ-032 Stimulus: rst pulsed asynchronously (between clock edges) after 4 shifts. Required: all outputs 0 immediately, no done pulse; a fresh load of 8'h81 then completes normally.
REQ-033 Configuration: WIDTH=1. Stimulus: din=1'b1, load, one shift_en. Required: sout=1 for one cycle; done asserted on the next cycle.
